// File: rtl/apes_pkg.sv
// Shared definitions for the APES readout chain: channel/word defaults,
// FSM state encoding and the system clock rate used to size the window.
package apes_pkg;

  localparam int N_CH_DEF = 53;
  localparam int CW_DEF   = 10;
  localparam int TW_DEF   = 26;
  localparam int CLK_HZ   = 50000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

endpackage

// File: rtl/anode_count_accum_chan_counter.sv
// chan_counter: one anode channel. Tracks the previous event level every
// cycle, detects rising edges and counts them while enabled.
// Optional macro COUNT_SAT_EN: counter saturates at all-ones instead of wrapping.
module chan_counter #(
  parameter int CW = 10
) (
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          i_event,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_count
);

  logic          r_prev;
  logic [CW-1:0] r_count;
  logic          w_rise;

  assign w_rise  = i_event & ~r_prev;
  assign o_count = r_count;

  // Previous-level register runs in every state so a held level never re-counts.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_event;
    end
  end

  // Edge counter: clear has priority, then count qualified rising edges.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && w_rise) begin
`ifdef COUNT_SAT_EN
      if (r_count != {CW{1'b1}}) begin
        r_count <= r_count + 1'b1;
      end
`else
      r_count <= r_count + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/anode_count_accum.sv
// anode_count_accum: accumulates per-channel rising-edge counts over a fixed
// window started by cnt_start, then freezes them with collect_done high until
// cnt_clr. Holds the window FSM and timer; channels live in chan_counter.
// Optional macro COUNT_SAT_EN: counters saturate instead of wrapping.
// Control interface: cnt_start/cnt_clr are single-cycle pulses with no
// handshake; cnt_clr beats cnt_start when both arrive in one cycle.
module anode_count_accum
  import apes_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int CW         = CW_DEF,
  parameter int WINDOW_CYC = CLK_HZ,
  parameter int TW         = TW_DEF
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    event_in,
  input  logic               cnt_start,
  input  logic               cnt_clr,
  output logic [N_CH*CW-1:0] counts,
  output logic               collect_done,
  output logic               collecting,
  output logic [1:0]         dbg_state
);

  localparam logic [TW-1:0] LP_LOAD = TW'(WINDOW_CYC - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_collect_done;
  logic          r_collecting;
  logic          w_cnt_en;

  assign collect_done = r_collect_done;
  assign collecting   = r_collecting;
  assign dbg_state    = r_state;

  // Edges in a clear cycle are dropped along with the clear itself.
  assign w_cnt_en = (r_state == ST_COLLECT) && !cnt_clr;

  // Window FSM with countdown timer; flags registered alongside the state.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_collect_done <= 1'b0;
      r_collecting   <= 1'b0;
    end else if (cnt_clr) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_collect_done <= 1'b0;
      r_collecting   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cnt_start) begin
            r_state      <= ST_COLLECT;
            r_timer      <= LP_LOAD;
            r_collecting <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (r_timer == '0) begin
            r_state        <= ST_DONE;
            r_collecting   <= 1'b0;
            r_collect_done <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DONE: begin
          r_collect_done <= 1'b1;
        end
        default: begin
          r_state        <= ST_IDLE;
          r_timer        <= '0;
          r_collect_done <= 1'b0;
          r_collecting   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    chan_counter #(.CW(CW)) u_chan (
      .clk50   (clk50),
      .rst_n   (rst_n),
      .i_event (event_in[g]),
      .i_en    (w_cnt_en),
      .i_clr   (cnt_clr),
      .o_count (counts[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_anode_count_accum.sv
// Directed bench for anode_count_accum: window timing, edge counting,
// mid-window clear, start/clear collision and counter overflow.
module tb_anode_count_accum;

  localparam int N_CH = 53;
  localparam int CW   = 10;
  localparam int WA   = 100;
  localparam int WB   = 4000;
  localparam int VW   = N_CH * CW;

  logic          clk50 = 1'b0;
  logic          rst_n = 1'b0;

  logic [N_CH-1:0] ev_a = '0;
  logic            start_a = 1'b0;
  logic            clr_a = 1'b0;
  logic [VW-1:0]   counts_a;
  logic            done_a;
  logic            coll_a;
  logic [1:0]      st_a;

  logic [N_CH-1:0] ev_b = '0;
  logic            start_b = 1'b0;
  logic            clr_b = 1'b0;
  logic [VW-1:0]   counts_b;
  logic            done_b;
  logic            coll_b;
  logic [1:0]      st_b;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] exp_v;
  logic          seen;
  logic [CW-1:0] exp_w2;

  // Clock / reset
  always #5 clk50 = ~clk50;

  anode_count_accum #(.N_CH(N_CH), .CW(CW), .WINDOW_CYC(WA), .TW(26)) dut_a (
    .clk50(clk50), .rst_n(rst_n), .event_in(ev_a), .cnt_start(start_a),
    .cnt_clr(clr_a), .counts(counts_a), .collect_done(done_a),
    .collecting(coll_a), .dbg_state(st_a)
  );

  anode_count_accum #(.N_CH(N_CH), .CW(CW), .WINDOW_CYC(WB), .TW(26)) dut_b (
    .clk50(clk50), .rst_n(rst_n), .event_in(ev_b), .cnt_start(start_b),
    .cnt_clr(clr_b), .counts(counts_b), .collect_done(done_b),
    .collecting(coll_b), .dbg_state(st_b)
  );

  // Driver: advance one clock, settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int ch, input logic [CW-1:0] val);
    exp_v[ch*CW +: CW] = val;
  endtask

  initial begin
    exp_v = '0;
    repeat (3) step();
    check("rst_counts", counts_a, '0);
    check("rst_done", VW'(done_a), '0);
    check("rst_collecting", VW'(coll_a), '0);
    check("rst_state", VW'(st_a), VW'(2'b00));
    rst_n = 1'b1;
    repeat (2) step();

    // Window A: start, then a mix of events inside the window.
    start_a = 1'b1; step(); start_a = 1'b0;           // edge k
    check("win_collecting_first", VW'(coll_a), VW'(1));
    check("win_state_collect", VW'(st_a), VW'(2'b01));
    for (int i = 0; i < 7; i++) begin                 // 14 steps
      ev_a[0] = 1'b1;
      if (i < 3) ev_a[52] = 1'b1;
      step();
      ev_a[0] = 1'b0; ev_a[52] = 1'b0;
      step();
    end
    check("mid_word0", VW'(counts_a[0 +: CW]), VW'(7));
    start_a = 1'b1; step(); start_a = 1'b0;           // n=15, ignored start
    check("start_in_collect_state", VW'(st_a), VW'(2'b01));
    ev_a[5] = 1'b1;
    repeat (40) step();                               // n=55
    ev_a[5] = 1'b0;
    step();                                           // n=56
    repeat (WA - 1 - 56) step();                      // n=99
    check("win_last_collecting", VW'(coll_a), VW'(1));
    check("win_last_not_done", VW'(done_a), '0);
    ev_a[6] = 1'b1;
    step();                                           // n=100, last COLLECT edge
    ev_a[6] = 1'b0;
    check("win_end_collecting", VW'(coll_a), '0);
    check("win_end_done", VW'(done_a), VW'(1));
    check("win_end_state", VW'(st_a), VW'(2'b10));
    set_word(0, 10'd7); set_word(52, 10'd3); set_word(5, 10'd1); set_word(6, 10'd1);
    check("win_counts", counts_a, exp_v);

    // Start and events during DONE change nothing.
    start_a = 1'b1; step(); start_a = 1'b0; step();
    for (int i = 0; i < 2; i++) begin
      ev_a[0] = 1'b1; step(); ev_a[0] = 1'b0; step();
    end
    check("done_hold_done", VW'(done_a), VW'(1));
    check("done_hold_collecting", VW'(coll_a), '0);
    check("done_hold_counts", counts_a, exp_v);

    // Clear from DONE, then events in IDLE are ignored.
    clr_a = 1'b1; step(); clr_a = 1'b0;
    check("clr_state", VW'(st_a), VW'(2'b00));
    check("clr_done", VW'(done_a), '0);
    check("clr_counts", counts_a, '0);
    ev_a[3] = 1'b1; step(); ev_a[3] = 1'b0; step();
    check("idle_no_count", counts_a, '0);

    // Mid-window clear.
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_a[1] = 1'b1; step(); ev_a[1] = 1'b0; step();
    end
    check("pre_clr_word1", VW'(counts_a[1*CW +: CW]), VW'(4));
    ev_a[1] = 1'b1; clr_a = 1'b1; step(); clr_a = 1'b0; ev_a[1] = 1'b0;
    check("midclr_word1", VW'(counts_a[1*CW +: CW]), '0);
    check("midclr_collecting", VW'(coll_a), '0);
    check("midclr_state", VW'(st_a), VW'(2'b00));
    seen = 1'b0;
    repeat (WA + 20) begin
      step();
      if (done_a || coll_a) seen = 1'b1;
    end
    check("midclr_never_done", VW'(seen), '0);

    // Clear and start together: clear wins.
    clr_a = 1'b1; start_a = 1'b1; step(); clr_a = 1'b0; start_a = 1'b0;
    check("clr_start_state", VW'(st_a), VW'(2'b00));
    check("clr_start_collecting", VW'(coll_a), '0);
    step();
    check("clr_start_still_idle", VW'(st_a), VW'(2'b00));

    // Window B: 1030 edges on channel 2.
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      ev_b[2] = 1'b1; step(); ev_b[2] = 1'b0; step();
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if (done_b) seen = 1'b1;
    end
    check("b_done_reached", VW'(seen), VW'(1));
`ifdef COUNT_SAT_EN
    exp_w2 = 10'd1023;
`else
    exp_w2 = 10'd6;
`endif
    check("b_word2", VW'(counts_b[2*CW +: CW]), VW'(exp_w2));
    exp_v = '0;
    set_word(2, exp_w2);
    check("b_counts", counts_b, exp_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
